// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU command issuer.
//   - ALU_W          : datapath width of the attached ALU
//   - OP_*           : 4-bit command opcodes (OP_ILLEGAL has no ALU mapping)
//   - SEL_*          : 5-bit ALU select codes
//   - state_e        : issuer FSM state encoding
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [3:0] OP_PASS    = 4'd0;
    localparam logic [3:0] OP_INC     = 4'd1;
    localparam logic [3:0] OP_ADD     = 4'd2;
    localparam logic [3:0] OP_ADDC    = 4'd3;
    localparam logic [3:0] OP_ADDNB   = 4'd4;
    localparam logic [3:0] OP_ADDNB1  = 4'd5;
    localparam logic [3:0] OP_DEC     = 4'd6;
    localparam logic [3:0] OP_PASSC   = 4'd7;
    localparam logic [3:0] OP_AND     = 4'd8;
    localparam logic [3:0] OP_OR      = 4'd9;
    localparam logic [3:0] OP_XOR     = 4'd10;
    localparam logic [3:0] OP_NOTA    = 4'd11;
    localparam logic [3:0] OP_SHL     = 4'd12;
    localparam logic [3:0] OP_SHR     = 4'd13;
    localparam logic [3:0] OP_CLR     = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    localparam logic [4:0] SEL_PASS  = 5'b00000;
    localparam logic [4:0] SEL_ADD   = 5'b00001;
    localparam logic [4:0] SEL_ADDNB = 5'b00010;
    localparam logic [4:0] SEL_DEC   = 5'b00011;
    localparam logic [4:0] SEL_AND   = 5'b00100;
    localparam logic [4:0] SEL_OR    = 5'b00101;
    localparam logic [4:0] SEL_XOR   = 5'b00110;
    localparam logic [4:0] SEL_NOTA  = 5'b00111;
    localparam logic [4:0] SEL_SHL   = 5'b01000;
    localparam logic [4:0] SEL_SHR   = 5'b10000;
    localparam logic [4:0] SEL_CLR   = 5'b11000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode -> ALU control translation.
//   op_i      in   4   command opcode
//   sel_o     out  5   ALU select code
//   cin_o     out  1   ALU carry-in
//   illegal_o out  1   opcode has no ALU mapping
// Only the sixteen table entries can ever be produced, so the ALU's
// undefined select codes are never driven.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op_i,
    output logic [4:0] sel_o,
    output logic       cin_o,
    output logic       illegal_o
);

    // Opcode table lookup; unmapped opcodes fall back to PASS with illegal set.
    always_comb begin
        sel_o     = SEL_PASS;
        cin_o     = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_PASS:    begin sel_o = SEL_PASS;  cin_o = 1'b0; end
            OP_INC:     begin sel_o = SEL_PASS;  cin_o = 1'b1; end
            OP_ADD:     begin sel_o = SEL_ADD;   cin_o = 1'b0; end
            OP_ADDC:    begin sel_o = SEL_ADD;   cin_o = 1'b1; end
            OP_ADDNB:   begin sel_o = SEL_ADDNB; cin_o = 1'b0; end
            OP_ADDNB1:  begin sel_o = SEL_ADDNB; cin_o = 1'b1; end
            OP_DEC:     begin sel_o = SEL_DEC;   cin_o = 1'b0; end
            OP_PASSC:   begin sel_o = SEL_DEC;   cin_o = 1'b1; end
            OP_AND:     begin sel_o = SEL_AND;   cin_o = 1'b0; end
            OP_OR:      begin sel_o = SEL_OR;    cin_o = 1'b0; end
            OP_XOR:     begin sel_o = SEL_XOR;   cin_o = 1'b0; end
            OP_NOTA:    begin sel_o = SEL_NOTA;  cin_o = 1'b0; end
            OP_SHL:     begin sel_o = SEL_SHL;   cin_o = 1'b0; end
            OP_SHR:     begin sel_o = SEL_SHR;   cin_o = 1'b0; end
            OP_CLR:     begin sel_o = SEL_CLR;   cin_o = 1'b0; end
            OP_ILLEGAL: begin illegal_o = 1'b1; end
            default:    begin illegal_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command-side initiator for an 8-bit combinational ALU.
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b, cmd_acc opcode, operands, use-accumulator flag
//   alu_sel/alu_cin/alu_a/alu_b  registered drive to the ALU
//   alu_y                        combinational ALU result
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_zero, rsp_err  result, zero flag, illegal-opcode flag
//   acc                          accumulator (result of last legal op)
// Sequence per op: IDLE (accept) -> DRIVE (ALU inputs settle, capture y)
// -> CAPT (raise rsp_valid) -> RESP (wait for rsp_ready) -> IDLE.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int W   = ALU_W,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    input  logic           cmd_acc,
    output logic [4:0]     alu_sel,
    output logic           alu_cin,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_zero,
    output logic           rsp_err,
    output logic [W-1:0]   acc
);

    state_e         state_q, state_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic [4:0]     alu_sel_q, alu_sel_d;
    logic           alu_cin_q, alu_cin_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic           rsp_err_q, rsp_err_d;
    logic [W-1:0]   acc_q, acc_d;

    logic [4:0]     dec_sel_s;
    logic           dec_cin_s;
    logic           dec_illegal_s;

    alu_op_decode u_decode (
        .op_i      (cmd_op[3:0]),
        .sel_o     (dec_sel_s),
        .cin_o     (dec_cin_s),
        .illegal_o (dec_illegal_s)
    );

    // Next-state and next-register logic; every register holds by default.
    always_comb begin
        state_d     = state_q;
        alu_sel_d   = alu_sel_q;
        alu_cin_d   = alu_cin_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        acc_d       = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (dec_illegal_s) begin
                        // Illegal op skips the ALU entirely; ALU regs and acc keep their values.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = {W{1'b0}};
                        rsp_zero_d  = 1'b1;
                    end else begin
                        state_d   = ST_DRIVE;
                        alu_sel_d = dec_sel_s;
                        alu_cin_d = dec_cin_s;
                        alu_a_d   = cmd_acc ? acc_q : cmd_a;
                        alu_b_d   = cmd_b;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // ALU inputs have been stable for a full cycle; take y now.
                rsp_data_d = alu_y;
                acc_d      = alu_y;
                rsp_err_d  = 1'b0;
                state_d    = ST_CAPT;
            end
            ST_CAPT: begin
                rsp_valid_d = 1'b1;
                rsp_zero_d  = (rsp_data_q == {W{1'b0}});
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // cmd_ready is registered and tracks the state we are about to enter,
        // so it rises the cycle after a response handshake.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State, operand, accumulator and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            alu_sel_q   <= 5'b00000;
            alu_cin_q   <= 1'b0;
            alu_a_q     <= {W{1'b0}};
            alu_b_q     <= {W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {W{1'b0}};
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            acc_q       <= {W{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            alu_sel_q   <= alu_sel_d;
            alu_cin_q   <= alu_cin_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
            acc_q       <= acc_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_sel   = alu_sel_q;
    assign alu_cin   = alu_cin_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign acc       = acc_q;

endmodule
